button_debounce: RTL and testbench
==================================

Name: button_debounce

Overview:
- Conditions a raw, asynchronous, bouncing push-button input into clean signals for downstream timing blocks.
- Sits directly upstream of the 1-second delay/LED stage. Its `btn_level` or `btn_rise` drives that stage's clear input in place of the raw button.
- Processing chain: 2-flop synchroniser, then a 4-state debounce FSM with a stability counter, then one-cycle edge pulses and a wrapping press counter.

Parameters:
- CNT_MAX, 1_000_000, number of consecutive stable samples needed to accept a level change (10 ms at 100 MHz); legal range 2 .. 2^CNT_W-1.
- CNT_W, 20, stability counter width; must satisfy 2^CNT_W > CNT_MAX.
- PCNT_W, 8, press counter width.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  reset: one clock, synchronous, active-high.
- btn_raw  input  1  raw button pin; asynchronous, may bounce.
- btn_level  output  1  debounced button level.
- btn_rise  output  1  one-cycle pulse on each accepted press.
- btn_fall  output  1  one-cycle pulse on each accepted release.
- press_cnt  output  PCNT_W  count of accepted presses; wraps.

Behaviour:
- Reset:
  - Applies when rst is high at a clk rising edge.
  - Clears both synchroniser flops, the stability counter, btn_level, btn_rise, btn_fall and press_cnt to 0.
  - FSM returns to IDLE.
  - Reset overrides every other event in the same cycle.
- Synchroniser:
  - sync1 <= btn_raw; sync2 <= sync1.
  - The FSM sees only sync2, which lags btn_raw by 2 edges.
- FSM states, all decisions on sync2:
  - IDLE (level 0): sync2=1 -> DB_PRESS with cnt<=0; otherwise stay.
  - DB_PRESS:
    - sync2=0 -> IDLE. Treated as bounce; no output change.
    - sync2=1 and cnt==CNT_MAX-1 -> HELD; btn_level<=1, btn_rise<=1, press_cnt<=press_cnt+1.
    - Otherwise cnt<=cnt+1.
  - HELD (level 1): sync2=0 -> DB_RELEASE with cnt<=0; otherwise stay.
  - DB_RELEASE:
    - sync2=1 -> HELD. Treated as bounce; level stays 1 and no pulse.
    - sync2=0 and cnt==CNT_MAX-1 -> IDLE; btn_level<=0, btn_fall<=1.
    - Otherwise cnt<=cnt+1.
- Pulses:
  - btn_rise and btn_fall are registered and high for exactly one cycle.
  - Default value is 0 in every cycle not listed above.
  - Both are never high in the same cycle.
- Latency:
  - Take btn_raw as stable from rising edge E0 onward.
  - btn_level/btn_rise change at edge E0+CNT_MAX+2, i.e. become visible after CNT_MAX+3 edges.
  - Release latency is identical.
- Bounce filtering:
  - Any glitch shorter than CNT_MAX cycles (as seen on sync2) produces no output change.
  - A glitch restarts the count from 0 on the next qualifying edge.
- press_cnt: unsigned; wraps from 2^PCNT_W-1 to 0 with no saturation and no flag.
- Reset mid-operation:
  - Any state returns to IDLE with outputs at 0.
  - If the button is still held when rst drops, the hold is re-debounced.
  - It produces a fresh btn_rise and press_cnt=1 after CNT_MAX+3 edges.
- Held indefinitely: stays in HELD; no repeat pulses; the counter does not run in HELD or IDLE.

Decomposition:
- Shared package (board_pkg):
  - FSM state encoding (IDLE=2'd0, DB_PRESS=2'd1, HELD=2'd2, DB_RELEASE=2'd3).
  - CLK_HZ=100_000_000.
  - DEBOUNCE_10MS=1_000_000.
- Sub-module sync_2ff, the generic 1-bit two-flop synchroniser with synchronous reset.
  - Instantiated once here.
  - Reused by the other button inputs.
- FSM, counter and pulse logic live in button_debounce.

Test Plan (CNT_MAX=8):
- Reset: rst=1 for 3 cycles with btn_raw=1 -> all outputs 0. Release rst, hold btn_raw=1 -> btn_level=1, btn_rise=1 for one cycle, press_cnt=1, all at the 11th edge after rst drops.
- Clean press/release: btn_raw 0->1 held 20 cycles, then 1->0 held 20 cycles -> one btn_rise at edge +11 and one btn_fall 11 edges after the release. press_cnt=1.
- Bounce on press: btn_raw toggles 1,0,1,0 each lasting 3 cycles, then steady 1 -> no pulse during the toggling. A single btn_rise 11 edges after the final steady 1. press_cnt increments by exactly 1.
- Bounce on release: while HELD, btn_raw=0 for 5 cycles then back to 1 -> btn_level stays 1 and no btn_fall.
- Wrap: 256 clean presses -> press_cnt reads 255 after press 255 and 0 after press 256. 256 rise pulses are counted.
- Reset mid-debounce: assert rst in DB_PRESS at cnt=5 -> outputs 0. With the button held, btn_rise follows 11 edges after rst drops, with no earlier pulse.

Source files
------------

// File: rtl/board_pkg.sv
// Shared board-level definitions: button debounce FSM state encoding and
// clock/timing constants used by the button conditioning and timing blocks.
package board_pkg;

    localparam int unsigned CLK_HZ        = 100_000_000;
    // Stable samples for a 10 ms debounce window at CLK_HZ.
    localparam int unsigned DEBOUNCE_10MS = 1_000_000;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } db_state_t;

endpackage : board_pkg

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser with synchronous active-high reset.
// Ports:
//   clk  - destination clock
//   rst  - synchronous reset, clears both flops
//   d    - asynchronous input
//   q    - synchronised output, lags d by two clk edges
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; second flop gives it a cycle to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : sync_2ff

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronises a raw bouncing button, accepts a
// level change only after CNT_MAX consecutive stable samples, and produces
// one-cycle press/release pulses plus a wrapping press counter.
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   btn_raw   - raw asynchronous button pin
//   btn_level - debounced button level
//   btn_rise  - one-cycle pulse per accepted press
//   btn_fall  - one-cycle pulse per accepted release
//   press_cnt - count of accepted presses, wraps
module button_debounce
    import board_pkg::*;
#(
    parameter int unsigned CNT_MAX = DEBOUNCE_10MS,
    parameter int unsigned CNT_W   = 20,
    parameter int unsigned PCNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_raw,
    output logic              btn_level,
    output logic              btn_rise,
    output logic              btn_fall,
    output logic [PCNT_W-1:0] press_cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic             btn_sync;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (btn_sync)
    );

    // Debounce FSM; counter only runs in the two debounce states.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
            btn_fall  <= 1'b0;
            press_cnt <= '0;
        end else begin
            btn_rise <= 1'b0;
            btn_fall <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_sync) begin
                        state <= DB_PRESS;
                        cnt   <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!btn_sync) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state     <= HELD;
                        btn_level <= 1'b1;
                        btn_rise  <= 1'b1;
                        press_cnt <= press_cnt + PCNT_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!btn_sync) begin
                        state <= DB_RELEASE;
                        cnt   <= '0;
                    end
                end
                DB_RELEASE: begin
                    if (btn_sync) begin
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        btn_level <= 1'b0;
                        btn_fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : button_debounce

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce with CNT_MAX=8.
module tb_button_debounce;

    localparam int unsigned CNT_MAX = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned PCNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              btn_raw = 1'b1;
    logic              btn_level;
    logic              btn_rise;
    logic              btn_fall;
    logic [PCNT_W-1:0] press_cnt;

    int checks = 0;
    int errors = 0;

    button_debounce #(
        .CNT_MAX (CNT_MAX),
        .CNT_W   (CNT_W),
        .PCNT_W  (PCNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .press_cnt (press_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: two-sample input delay, then accept a new level once
    // the delayed input has differed from the current level for CNT_MAX+1
    // consecutive edges.
    logic              m_d1 = 1'b0, m_d2 = 1'b0;
    int                m_run = 0;
    logic              m_level = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
    logic [PCNT_W-1:0] m_pc = '0;
    bit                m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_d1 = 1'b0; m_d2 = 1'b0; m_run = 0;
            m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_pc = '0;
            m_valid = 1'b1;
        end else begin
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (m_d2 != m_level) m_run = m_run + 1;
            else                 m_run = 0;
            if (m_run == int'(CNT_MAX) + 1) begin
                m_level = m_d2;
                m_run   = 0;
                if (m_d2) begin
                    m_rise = 1'b1;
                    m_pc   = m_pc + 8'd1;
                end else begin
                    m_fall = 1'b1;
                end
            end
            m_d2 = m_d1;
            m_d1 = btn_raw;
        end
    end

    // Per-cycle comparison against the model, plus pulse tallies.
    int rise_seen = 0;
    int fall_seen = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            checks = checks + 1;
            if (btn_level !== m_level || btn_rise !== m_rise ||
                btn_fall !== m_fall || press_cnt !== m_pc) begin
                errors = errors + 1;
                $display("FAIL model t=%0t: got lvl=%b rise=%b fall=%b cnt=%0d, need lvl=%b rise=%b fall=%b cnt=%0d",
                         $time, btn_level, btn_rise, btn_fall, press_cnt,
                         m_level, m_rise, m_fall, m_pc);
            end
            checks = checks + 1;
            if (btn_rise === 1'b1 && btn_fall === 1'b1) begin
                errors = errors + 1;
                $display("FAIL both_pulses t=%0t: got rise=1 fall=1, need not both", $time);
            end
        end
        if (btn_rise === 1'b1) rise_seen = rise_seen + 1;
        if (btn_fall === 1'b1) fall_seen = fall_seen + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input int got, input int need);
        checks = checks + 1;
        if (got != need) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, need %0d", name, got, need);
        end
    endtask

    int r0;

    initial begin
        // Reset with button held: outputs stay 0.
        rst = 1'b1; btn_raw = 1'b1;
        cyc(3);
        chk("rst_level", int'(btn_level), 0);
        chk("rst_rise", int'(btn_rise), 0);
        chk("rst_cnt", int'(press_cnt), 0);
        rst = 1'b0;
        cyc(10);
        chk("post_rst_e10_level", int'(btn_level), 0);
        cyc(1);
        chk("post_rst_e11_level", int'(btn_level), 1);
        chk("post_rst_e11_rise", int'(btn_rise), 1);
        chk("post_rst_e11_cnt", int'(press_cnt), 1);
        cyc(1);
        chk("post_rst_rise_once", int'(btn_rise), 0);

        // Release, then a clean press/release.
        btn_raw = 1'b0; cyc(20);
        chk("release1_level", int'(btn_level), 0);
        btn_raw = 1'b1;
        cyc(10);
        chk("clean_e10_rise", int'(btn_rise), 0);
        cyc(1);
        chk("clean_e11_rise", int'(btn_rise), 1);
        chk("clean_cnt", int'(press_cnt), 2);
        cyc(9);
        btn_raw = 1'b0;
        cyc(10);
        chk("clean_rel_e10_fall", int'(btn_fall), 0);
        cyc(1);
        chk("clean_rel_e11_fall", int'(btn_fall), 1);
        chk("clean_rel_level", int'(btn_level), 0);
        cyc(9);

        // Bounce on press: 1,0,1,0 for 3 cycles each, then steady 1.
        r0 = rise_seen;
        for (int i = 0; i < 4; i++) begin
            btn_raw = (i % 2 == 0) ? 1'b1 : 1'b0;
            cyc(3);
        end
        chk("bounce_no_rise", rise_seen - r0, 0);
        btn_raw = 1'b1;
        cyc(10);
        chk("bounce_e10_rise", rise_seen - r0, 0);
        cyc(1);
        chk("bounce_e11_rise", int'(btn_rise), 1);
        chk("bounce_cnt", int'(press_cnt), 3);
        cyc(9);

        // Bounce on release while held: level stays high, no fall.
        r0 = fall_seen;
        btn_raw = 1'b0; cyc(5);
        btn_raw = 1'b1; cyc(20);
        chk("rel_bounce_level", int'(btn_level), 1);
        chk("rel_bounce_no_fall", fall_seen - r0, 0);
        btn_raw = 1'b0; cyc(20);

        // Wrap: 256 clean presses from a fresh reset.
        rst = 1'b1; cyc(1); rst = 1'b0;
        r0 = rise_seen;
        for (int k = 1; k <= 256; k++) begin
            btn_raw = 1'b1; cyc(12);
            if (k == 255) chk("wrap_255", int'(press_cnt), 255);
            if (k == 256) chk("wrap_256", int'(press_cnt), 0);
            btn_raw = 1'b0; cyc(12);
        end
        chk("wrap_rises", rise_seen - r0, 256);

        // Reset mid-debounce (counter at 5), button still held afterwards.
        btn_raw = 1'b1;
        cyc(8);
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_level", int'(btn_level), 0);
        chk("mid_rst_cnt", int'(press_cnt), 0);
        rst = 1'b0;
        r0 = rise_seen;
        cyc(10);
        chk("mid_rst_no_early", rise_seen - r0, 0);
        cyc(1);
        chk("mid_rst_e11_rise", int'(btn_rise), 1);
        chk("mid_rst_e11_cnt", int'(press_cnt), 1);
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_button_debounce
